harris_frame_sequencer: RTL

- Frame-level controller that drives the harrisDetector pixel input.
- On a start pulse it reads one raster frame from a byte-wide synchronous frame memory and emits pixel/pixel_valid with sof/eol/eof markers and pixel coordinates.
- It inserts programmable horizontal blanking, then pushes flush pixels to drain the detector's line buffers.
- It reports busy/done and supports abort mid-frame.

---
 rtl/harris_frame_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/harris_frame_sequencer.sv
// Frame sequencer for the Harris detector: streams one raster frame from a byte-wide
// synchronous memory, then flush pixels, with sof/eol/eof markers and coordinates.
module harris_frame_sequencer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_W     = 19,
  parameter int HBLANK     = 4,
  parameter int FLUSH_PIX  = 1282
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [7:0]                    mem_rdata,
  output logic [7:0]                    pixel,
  output logic                          pixel_valid,
  output logic                          sof,
  output logic                          eol,
  output logic                          eof,
  output logic [$clog2(IMG_WIDTH)-1:0]  pix_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] pix_y,
  output logic                          busy,
  output logic                          done
);

  localparam int XW  = $clog2(IMG_WIDTH);
  localparam int YW  = $clog2(IMG_HEIGHT);
  localparam int HBW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam int FLW = (FLUSH_PIX > 1) ? $clog2(FLUSH_PIX) : 1;

  localparam logic [XW-1:0]  X_LAST  = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_HEIGHT - 1);
  localparam logic [HBW-1:0] HB_LAST = HBW'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [FLW-1:0] FL_LAST = FLW'((FLUSH_PIX > 0) ? FLUSH_PIX - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_HBLANK,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [XW-1:0]     x_reg;
  logic [YW-1:0]     y_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [HBW-1:0]    hb_cnt_reg;
  logic [FLW-1:0]    fl_cnt_reg;
  logic              drain_cnt_reg;

  logic line_end, last_line, fetch, flushing, clear_pipe;

  assign line_end   = (x_reg == X_LAST);
  assign last_line  = (y_reg == Y_LAST);
  assign fetch      = (state_reg == ST_FETCH);
  assign flushing   = (state_reg == ST_FLUSH);
  assign clear_pipe = abort && (state_reg != ST_IDLE);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start && !abort) state_next = ST_FETCH;
      ST_FETCH: begin
        if (line_end) begin
          if (!last_line)
            state_next = (HBLANK > 0) ? ST_HBLANK : ST_FETCH;
          else
            state_next = (FLUSH_PIX > 0) ? ST_FLUSH : ST_DRAIN;
        end
      end
      ST_HBLANK: if (hb_cnt_reg == HB_LAST) state_next = ST_FETCH;
      ST_FLUSH:  if (fl_cnt_reg == FL_LAST) state_next = ST_DRAIN;
      ST_DRAIN:  if (drain_cnt_reg) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (clear_pipe) state_next = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      addr_reg      <= '0;
      last_addr_reg <= '0;
      hb_cnt_reg    <= '0;
      fl_cnt_reg    <= '0;
      drain_cnt_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          x_reg    <= '0;
          y_reg    <= '0;
          addr_reg <= '0;
        end
        ST_FETCH: begin
          last_addr_reg <= addr_reg;
          addr_reg      <= addr_reg + 1'b1;
          hb_cnt_reg    <= '0;
          fl_cnt_reg    <= '0;
          drain_cnt_reg <= 1'b0;
          if (line_end) begin
            x_reg <= '0;
            y_reg <= y_reg + 1'b1;
          end else begin
            x_reg <= x_reg + 1'b1;
          end
        end
        ST_HBLANK: hb_cnt_reg <= hb_cnt_reg + 1'b1;
        ST_FLUSH: begin
          fl_cnt_reg    <= fl_cnt_reg + 1'b1;
          drain_cnt_reg <= 1'b0;
        end
        ST_DRAIN: drain_cnt_reg <= ~drain_cnt_reg;
        default: ;
      endcase
    end
  end

  // Address output holds the last issued address while no read is in progress.
  assign mem_rd_en = fetch;
  assign mem_addr  = fetch ? addr_reg : last_addr_reg;
  assign busy      = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done      = (state_reg == ST_DONE);

  // Stage 1: tag the request issued this cycle; marker bits are {sof, eol, eof}.
  logic          s1_valid_reg, s1_flush_reg;
  logic [XW-1:0] s1_x_reg;
  logic [YW-1:0] s1_y_reg;
  logic [2:0]    s1_mark_reg;

  always_ff @(posedge clk) begin
    if (!reset || clear_pipe) begin
      s1_valid_reg <= 1'b0;
      s1_flush_reg <= 1'b0;
      s1_x_reg     <= '0;
      s1_y_reg     <= '0;
      s1_mark_reg  <= '0;
    end else begin
      s1_valid_reg <= fetch || flushing;
      s1_flush_reg <= flushing;
      s1_x_reg     <= fetch ? x_reg : '0;
      s1_y_reg     <= fetch ? y_reg : '0;
      s1_mark_reg  <= {fetch && (x_reg == '0) && (y_reg == '0),
                       fetch && line_end,
                       fetch && line_end && last_line};
    end
  end

  // Stage 2: capture read data alongside the delayed tag.
  logic [7:0]    pixel_reg;
  logic          pixel_valid_reg;
  logic [XW-1:0] pix_x_reg;
  logic [YW-1:0] pix_y_reg;
  logic [2:0]    s2_mark_reg;

  always_ff @(posedge clk) begin
    if (!reset || clear_pipe) begin
      pixel_reg       <= '0;
      pixel_valid_reg <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
    end else begin
      pixel_reg       <= (s1_valid_reg && !s1_flush_reg) ? mem_rdata : 8'd0;
      pixel_valid_reg <= s1_valid_reg;
      pix_x_reg       <= s1_x_reg;
      pix_y_reg       <= s1_y_reg;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_mark
    always_ff @(posedge clk) begin
      if (!reset || clear_pipe)
        s2_mark_reg[gi] <= 1'b0;
      else
        s2_mark_reg[gi] <= s1_valid_reg && s1_mark_reg[gi];
    end
  end

  assign pixel       = pixel_reg;
  assign pixel_valid = pixel_valid_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign sof         = s2_mark_reg[2];
  assign eol         = s2_mark_reg[1];
  assign eof         = s2_mark_reg[0];

endmodule
